// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: shifter request/result handshake bundle; master drives flush, in_* and out_ready, slave drives in_ready and out_*
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMTW = 8,
  parameter int TAGW = 4
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [AMTW-1:0] in_amt;
  logic [2:0] in_op;
  logic in_c;
  logic [TAGW-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_y;
  logic out_c;
  logic [TAGW-1:0] out_tag;
  modport master (
    output flush, in_valid, in_a, in_amt, in_op, in_c, in_tag, out_ready,
    input in_ready, out_valid, out_y, out_c, out_tag
  );
  modport slave (
    input flush, in_valid, in_a, in_amt, in_op, in_c, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_c, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: PIPE-stage LSL/LSR/ASR/ROR/RRX unit with carry-out; ports clk, reset (sync, active-high), bus (slave: in_* request, out_* result, flush)
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int AMTW = 8,
  parameter int PIPE = 2,
  parameter int TAGW = 4
) (
  input logic clk,
  input logic reset,
  pipelined_shifter_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  typedef logic [LW-1:0] lw_t;
  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic cin;
    logic s;
    logic [2:0] op;
    logic nz;
    logic lt;
    logic eq;
    logic [LW-3:0] hi;
    lw_t nl;
    logic [TAGW-1:0] tag;
  } s1_t;
  function automatic logic [WIDTH-1:0] ror(logic [WIDTH-1:0] x, lw_t k);
    return WIDTH'({x, x} >> k);
  endfunction
  function automatic s1_t front(logic [WIDTH-1:0] a, logic [AMTW-1:0] n, logic [2:0] op, logic c, logic [TAGW-1:0] tag);
    lw_t nl, ra;
    nl = n[LW-1:0];
    ra = op == 3'd4 ? lw_t'(1) : op > 3'd4 ? '0 : op == 3'd0 ? -nl : nl;
    return '{f: ror(a, lw_t'(ra[1:0])), cin: c, s: a[WIDTH-1], op: op, nz: n == '0,
             lt: n < AMTW'(WIDTH), eq: n == AMTW'(WIDTH), hi: ra[LW-1:2], nl: nl, tag: tag};
  endfunction
  function automatic logic [WIDTH:0] back(s1_t s);
    logic [WIDTH-1:0] r, ml, mr, sx;
    r = ror(s.f, {s.hi, 2'b00});
    ml = ONES << s.nl;
    mr = ONES >> s.nl;
    sx = {WIDTH{s.s}};
    return (s.op > 3'd4 || (s.nz && s.op != 3'd4)) ? {r, s.cin} :
           s.op == 3'd4 ? {s.cin, r[WIDTH-2:0], r[WIDTH-1]} :
           s.op == 3'd3 ? {r, r[WIDTH-1]} :
           s.op == 3'd0 ? (s.lt ? {r & ml, r[0]} : {{WIDTH{1'b0}}, s.eq & r[0]}) :
           s.op == 3'd1 ? (s.lt ? {r & mr, r[WIDTH-1]} : {{WIDTH{1'b0}}, s.eq & r[WIDTH-1]}) :
           s.lt ? {(r & mr) | (sx & ~mr), r[WIDTH-1]} : {sx, s.s};
  endfunction
  logic out_v;
  logic [WIDTH-1:0] y_q;
  logic c_q;
  logic [TAGW-1:0] tag_q;
  logic adv_out;
  logic acc;
  assign adv_out = out_v & bus.out_ready;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_v;
  assign bus.out_y = y_q;
  assign bus.out_c = c_q;
  assign bus.out_tag = tag_q;
  if (PIPE == 2) begin : g_two
    s1_t s1;
    logic v1;
    logic adv1;
    logic [WIDTH:0] yc;
    assign adv1 = v1 & (~out_v | adv_out);
    assign bus.in_ready = ~bus.flush & (~v1 | adv1);
    assign yc = back(s1);
    always_ff @(posedge clk) begin
      if (reset) begin
        s1 <= '0;
        v1 <= 1'b0;
        out_v <= 1'b0;
        y_q <= '0;
        c_q <= 1'b0;
        tag_q <= '0;
      end else if (bus.flush) begin
        v1 <= 1'b0;
        out_v <= 1'b0;
      end else begin
        if (acc) s1 <= front(bus.in_a, bus.in_amt, bus.in_op, bus.in_c, bus.in_tag);
        v1 <= acc | (v1 & ~adv1);
        if (adv1) {y_q, c_q, tag_q} <= {yc, s1.tag};
        out_v <= adv1 | (out_v & ~adv_out);
      end
    end
  end else begin : g_one
    logic [WIDTH:0] yc;
    assign bus.in_ready = ~bus.flush & (~out_v | adv_out);
    assign yc = back(front(bus.in_a, bus.in_amt, bus.in_op, bus.in_c, bus.in_tag));
    always_ff @(posedge clk) begin
      if (reset) begin
        out_v <= 1'b0;
        y_q <= '0;
        c_q <= 1'b0;
        tag_q <= '0;
      end else if (bus.flush) begin
        out_v <= 1'b0;
      end else begin
        if (acc) {y_q, c_q, tag_q} <= {yc, bus.in_tag};
        out_v <= acc | (out_v & ~adv_out);
      end
    end
  end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: reference-model scoreboard plus directed, back-pressure, flush, reset and random stimulus for pipelined_shifter
module tb_pipelined_shifter;
  localparam int W = 32;
  localparam int AW = 8;
  localparam int PIPE = 2;
  localparam int TW = 4;
  typedef struct {
    logic [W-1:0] y;
    logic c;
    logic [TW-1:0] tag;
  } exp_t;
  typedef struct packed {
    logic [2:0] op;
    logic [W-1:0] a;
    logic [AW-1:0] n;
    logic c;
    logic [W-1:0] y;
    logic co;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  exp_t q[$];
  logic held = 1'b0;
  logic [W-1:0] hy;
  logic hc;
  logic [TW-1:0] ht;
  vec_t vecs [16] = '{
    '{3'd0, 32'h80000001, 8'd1,   1'b0, 32'h00000002, 1'b1},
    '{3'd1, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1},
    '{3'd1, 32'h80000001, 8'd33,  1'b0, 32'h00000000, 1'b0},
    '{3'd2, 32'h80000001, 8'd40,  1'b0, 32'hFFFFFFFF, 1'b1},
    '{3'd3, 32'h80000001, 8'd32,  1'b0, 32'h80000001, 1'b1},
    '{3'd3, 32'h80000001, 8'd36,  1'b0, 32'h18000000, 1'b0},
    '{3'd0, 32'h80000001, 8'd0,   1'b1, 32'h80000001, 1'b1},
    '{3'd4, 32'h00000003, 8'hFF,  1'b1, 32'h80000001, 1'b1},
    '{3'd1, 32'h80000001, 8'd4,   1'b0, 32'h08000000, 1'b0},
    '{3'd2, 32'h80000001, 8'd4,   1'b0, 32'hF8000000, 1'b0},
    '{3'd0, 32'h80000001, 8'd31,  1'b0, 32'h80000000, 1'b0},
    '{3'd0, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1},
    '{3'd6, 32'h12345678, 8'd5,   1'b1, 32'h12345678, 1'b1},
    '{3'd3, 32'h80000001, 8'd1,   1'b0, 32'hC0000000, 1'b1},
    '{3'd0, 32'h80000001, 8'd200, 1'b1, 32'h00000000, 1'b0},
    '{3'd2, 32'h70000000, 8'd4,   1'b0, 32'h07000000, 1'b0}
  };
  logic [AW-1:0] amts [8] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd36, 8'd64, 8'd255};
  always #5 clk = ~clk;
  pipelined_shifter_if #(.WIDTH(W), .AMTW(AW), .TAGW(TW)) bus ();
  pipelined_shifter #(.WIDTH(W), .AMTW(AW), .PIPE(PIPE), .TAGW(TW)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(logic [W-1:0] a, int n, logic [2:0] op, logic c, logic [TW-1:0] tag);
    exp_t e;
    int r;
    e.tag = tag;
    e.y = a;
    e.c = c;
    if (op == 3'd4) begin
      e.y = {c, a[W-1:1]};
      e.c = a[0];
    end else if (op < 3'd4 && n != 0) begin
      case (op)
        3'd0: begin
          if (n < W) begin e.y = a << n; e.c = a[W-n]; end
          else begin e.y = '0; e.c = (n == W) ? a[0] : 1'b0; end
        end
        3'd1: begin
          if (n < W) begin e.y = a >> n; e.c = a[n-1]; end
          else begin e.y = '0; e.c = (n == W) ? a[W-1] : 1'b0; end
        end
        3'd2: begin
          if (n < W) begin e.y = $signed(a) >>> n; e.c = a[n-1]; end
          else begin e.y = {W{a[W-1]}}; e.c = a[W-1]; end
        end
        default: begin
          r = n % W;
          if (r == 0) begin e.y = a; e.c = a[W-1]; end
          else begin e.y = (a >> r) | (a << (W - r)); e.c = e.y[W-1]; end
        end
      endcase
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) check("stall_hold", {bus.out_valid, bus.out_y, bus.out_c, bus.out_tag}, {1'b1, hy, hc, ht});
      held = bus.out_valid && !bus.out_ready && !bus.flush;
      hy = bus.out_y;
      hc = bus.out_c;
      ht = bus.out_tag;
      if (q.size() == 0) check("no_spurious_valid", bus.out_valid, 1'b0);
      else if (bus.out_valid) begin
        check("model_y", bus.out_y, q[0].y);
        check("model_c", bus.out_c, q[0].c);
        check("model_tag", bus.out_tag, q[0].tag);
        if (bus.out_ready && !bus.flush) void'(q.pop_front());
      end
      if (bus.flush) begin
        check("flush_blocks_in", bus.in_ready, 1'b0);
        q.delete();
      end else if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_a, int'(bus.in_amt), bus.in_op, bus.in_c, bus.in_tag));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [AW-1:0] n, input logic c, input logic [TW-1:0] tag);
    bus.in_op = op;
    bus.in_a = a;
    bus.in_amt = n;
    bus.in_c = c;
    bus.in_tag = tag;
  endtask
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [AW-1:0] n, input logic c, input logic [TW-1:0] tag);
    logic acc;
    int k = 0;
    drive(op, a, n, c, tag);
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      k++;
    end while (!acc && k < 20);
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1'b1);
  endtask
  task automatic expect_out(input string name, input logic [W-1:0] y, input logic c, input logic [TW-1:0] tag);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 20);
    check({name, "_latency"}, lat, PIPE);
    check(name, {bus.out_valid, bus.out_y, bus.out_c, bus.out_tag}, {1'b1, y, c, tag});
    tick();
  endtask
  initial begin
    int k;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, '0, '0, 1'b0, '0);
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {bus.out_valid, bus.out_y, bus.out_c, bus.out_tag}, '0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    tick();
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].n, vecs[i].c, TW'(i + 3));
      expect_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].co, TW'(i + 3));
    end
    k = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      bus.out_ready = (cyc >= 5);
      drive(3'd0, W'(32'h01010101 * (k + 1)), AW'(k), 1'b0, TW'(k));
      bus.in_valid = (k < 6);
      @(negedge clk);
      if (cyc == 3 || cyc == 4) check("bp_in_ready", bus.in_ready, 1'b0);
      if (cyc >= 5 && cyc <= 10) check("bp_order", {bus.out_valid, bus.out_tag}, {1'b1, TW'(cyc - 5)});
      if (bus.in_valid && bus.in_ready) k++;
      tick();
    end
    check("bp_accepts", k, 6);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      bus.flush = (cyc == 3);
      bus.out_ready = (cyc == 4);
      bus.in_valid = (cyc != 4);
      drive(3'd1, 32'hA5A5A5A5, AW'(cyc), 1'b0, TW'(cyc));
      @(negedge clk);
      if (cyc == 3) check("flush_in_ready", bus.in_ready, 1'b0);
      if (cyc == 4) check("flush_out_valid", bus.out_valid, 1'b0);
      tick();
    end
    bus.flush = 1'b0;
    send(3'd1, 32'hF0000000, 8'd4, 1'b0, 4'd9);
    expect_out("after_flush", 32'h0F000000, 1'b0, 4'd9);
    send(3'd2, 32'h80000000, 8'd3, 1'b0, 4'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_discard", bus.out_valid, 1'b0);
      tick();
    end
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 63) == 0;
      drive(3'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0 ? 32'h80000001 : W'($urandom),
            $urandom_range(0, 1) == 1 ? amts[$urandom_range(0, 7)] : AW'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end
endmodule
